pulse_cmp_array: RTL and testbench



---
 rtl/pulse_cmp_pkg.sv | 25 ++
 rtl/pulse_cmp_ch.sv | 109 ++++++++++
 rtl/pulse_cmp_array.sv | 42 ++++
 tb/tb_pulse_cmp_array.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_cmp_pkg.sv
// Shared types for the pulse-order comparator array.
// Per-channel state, update-operand select codes and the direction each select implies.
package pulse_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    X_ONLY = 2'd1,
    Y_ONLY = 2'd2,
    BOTH   = 2'd3
  } cmp_state_t;

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_CAPTURE = 3'd1,
    SEL_MINUS   = 3'd2,
    SEL_SEARCH  = 3'd3,
    SEL_BACKOFF = 3'd4
  } upd_sel_t;

  // Capture and search potentiate; minus and backoff depress.
  function automatic logic sel_is_inc(input upd_sel_t sel);
    return (sel == SEL_CAPTURE) || (sel == SEL_SEARCH);
  endfunction

endpackage

// File: rtl/pulse_cmp_ch.sv
// One comparator channel: pulse-order FSM, operand select and registered update outputs.
// Optional build macro PULSE_TIE_MINUS_EN: a same-cycle x/y tie emits u_minus (inc=0) instead of u_capture.
//
// state  | meaning
// IDLE   | window open, neither pulse arrived yet
// X_ONLY | x seen, waiting for y
// Y_ONLY | y seen, waiting for x
// BOTH   | order resolved and emitted; rest of window ignored
module pulse_cmp_ch
  import pulse_cmp_pkg::*;
#(
  parameter int PW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gamma_end,
  input  logic          ch_en,
  input  logic          x_pulse,
  input  logic          y_pulse,
  input  logic [PW-1:0] u_capture,
  input  logic [PW-1:0] u_minus,
  input  logic [PW-1:0] u_search,
  input  logic [PW-1:0] u_backoff,
  output logic          upd_valid,
  output logic          upd_inc,
  output logic [PW-1:0] upd_prob
);

`ifdef PULSE_TIE_MINUS_EN
  localparam upd_sel_t TIE_SEL = SEL_MINUS;
`else
  localparam upd_sel_t TIE_SEL = SEL_CAPTURE;
`endif

  cmp_state_t    state, next_state, pulse_state;
  upd_sel_t      sel;
  logic [PW-1:0] sel_prob;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    pulse_state = state;
    sel         = SEL_NONE;
    next_state  = state;

    case (state)
      IDLE: begin
        if (x_pulse && y_pulse) begin
          pulse_state = BOTH;
          sel         = TIE_SEL;
        end else if (x_pulse) begin
          pulse_state = X_ONLY;
        end else if (y_pulse) begin
          pulse_state = Y_ONLY;
        end
      end
      X_ONLY: if (y_pulse) begin
        pulse_state = BOTH;
        sel         = SEL_CAPTURE;
      end
      Y_ONLY: if (x_pulse) begin
        pulse_state = BOTH;
        sel         = SEL_MINUS;
      end
      default: pulse_state = BOTH;
    endcase

    // Close acts on the post-pulse state, so a same-cycle order emission blocks the close one.
    if (gamma_end) begin
      next_state = IDLE;
      if (pulse_state == X_ONLY)      sel = SEL_SEARCH;
      else if (pulse_state == Y_ONLY) sel = SEL_BACKOFF;
    end else begin
      next_state = pulse_state;
    end

    if (!ch_en) begin
      next_state = IDLE;
      sel        = SEL_NONE;
    end
  end

  always_comb begin
    sel_prob = '0;
    case (sel)
      SEL_CAPTURE: sel_prob = u_capture;
      SEL_MINUS:   sel_prob = u_minus;
      SEL_SEARCH:  sel_prob = u_search;
      SEL_BACKOFF: sel_prob = u_backoff;
      default:     sel_prob = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid <= 1'b0;
      upd_inc   <= 1'b0;
      upd_prob  <= '0;
    end else begin
      upd_valid <= (sel != SEL_NONE);
      upd_inc   <= sel_is_inc(sel);
      upd_prob  <= sel_prob;
    end
  end

endmodule

// File: rtl/pulse_cmp_array.sv
// N_CH-channel pulse-order comparator; y_pulse, gamma_end and operands are shared.
// Tie handling follows the PULSE_TIE_MINUS_EN build macro inside pulse_cmp_ch.
module pulse_cmp_array
  import pulse_cmp_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int PW   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gamma_end,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [N_CH-1:0]  x_pulse,
  input  logic             y_pulse,
  input  logic [PW-1:0]    u_capture,
  input  logic [PW-1:0]    u_minus,
  input  logic [PW-1:0]    u_search,
  input  logic [PW-1:0]    u_backoff,
  output logic [N_CH-1:0]  upd_valid,
  output logic [N_CH-1:0]  upd_inc,
  output logic [N_CH*PW-1:0] upd_prob
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_cmp_ch #(.PW(PW)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .gamma_end (gamma_end),
      .ch_en     (ch_en[i]),
      .x_pulse   (x_pulse[i]),
      .y_pulse   (y_pulse),
      .u_capture (u_capture),
      .u_minus   (u_minus),
      .u_search  (u_search),
      .u_backoff (u_backoff),
      .upd_valid (upd_valid[i]),
      .upd_inc   (upd_inc[i]),
      .upd_prob  (upd_prob[i*PW +: PW])
    );
  end

endmodule

// File: tb/tb_pulse_cmp_array.sv
// Bench for pulse_cmp_array: directed scenarios then 100 random windows against a window-level model.
// The model tracks "x seen / y seen / already emitted" per channel and window.
module tb_pulse_cmp_array;
  localparam int N_CH = 8;
  localparam int PW   = 7;

  logic              clk = 1'b0;
  logic              rst, gamma_end, y_pulse;
  logic [N_CH-1:0]   ch_en, x_pulse;
  logic [PW-1:0]     u_capture, u_minus, u_search, u_backoff;
  logic [N_CH-1:0]   upd_valid, upd_inc;
  logic [N_CH*PW-1:0] upd_prob;

  pulse_cmp_array #(.N_CH(N_CH), .PW(PW)) dut (
    .clk(clk), .rst(rst), .gamma_end(gamma_end), .ch_en(ch_en),
    .x_pulse(x_pulse), .y_pulse(y_pulse),
    .u_capture(u_capture), .u_minus(u_minus), .u_search(u_search), .u_backoff(u_backoff),
    .upd_valid(upd_valid), .upd_inc(upd_inc), .upd_prob(upd_prob)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit xs [N_CH];
  bit ys [N_CH];
  bit done [N_CH];
  logic [N_CH-1:0]    ev, ei;
  logic [N_CH*PW-1:0] ep;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_ch(input int ch);
    xs[ch] = 0; ys[ch] = 0; done[ch] = 0;
  endtask

  // Predict this edge's outputs from the currently driven inputs.
  task automatic model_cycle();
    ev = '0; ei = '0; ep = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      int code;
      logic [PW-1:0] p;
      logic inc;
      code = 0;
      if (rst || !ch_en[ch]) begin
        clear_ch(ch);
      end else begin
        if (!done[ch]) begin
          if (x_pulse[ch] && y_pulse && !xs[ch] && !ys[ch]) begin
`ifdef PULSE_TIE_MINUS_EN
            code = 2;
`else
            code = 1;
`endif
          end else if (y_pulse && xs[ch]) code = 1;
          else if (x_pulse[ch] && ys[ch]) code = 2;
          if (x_pulse[ch]) xs[ch] = 1;
          if (y_pulse)     ys[ch] = 1;
          if (code != 0) done[ch] = 1;
          if (gamma_end && !done[ch]) begin
            if (xs[ch])      code = 3;
            else if (ys[ch]) code = 4;
          end
        end
        if (gamma_end) clear_ch(ch);
      end
      case (code)
        1: begin p = u_capture; inc = 1'b1; end
        2: begin p = u_minus;   inc = 1'b0; end
        3: begin p = u_search;  inc = 1'b1; end
        4: begin p = u_backoff; inc = 1'b0; end
        default: begin p = '0; inc = 1'b0; end
      endcase
      ev[ch] = (code != 0);
      ei[ch] = inc;
      ep[ch*PW +: PW] = p;
    end
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    chk("upd_valid", 64'(upd_valid), 64'(ev));
    chk("upd_inc",   64'(upd_inc),   64'(ei));
    chk("upd_prob",  64'(upd_prob),  64'(ep));
  endtask

  task automatic quiet();
    x_pulse = '0; y_pulse = 1'b0; gamma_end = 1'b0;
  endtask

  function automatic logic [PW-1:0] prob_of(input int ch);
    return upd_prob[ch*PW +: PW];
  endfunction

  int cnt [N_CH];
  bit had [N_CH];

  initial begin
    u_capture = 7'd90; u_minus = 7'd20; u_search = 7'd60; u_backoff = 7'd5;
    ch_en = '1; rst = 1'b1; quiet();
    for (int i = 0; i < N_CH; i++) clear_ch(i);
    tick(); tick();
    chk("reset_valid", 64'(upd_valid), 64'd0);
    chk("reset_prob",  64'(upd_prob),  64'd0);
    rst = 1'b0;

    // pulse order x then y on ch0
    tick();
    x_pulse = 8'h01; tick(); quiet();
    tick(); tick();
    y_pulse = 1'b1; tick(); quiet();
    chk("order_valid0", 64'(upd_valid[0]), 64'd1);
    chk("order_prob0",  64'(prob_of(0)),   64'd90);
    chk("order_inc0",   64'(upd_inc[0]),   64'd1);
    tick(); tick();
    gamma_end = 1'b1; tick(); quiet();
    chk("order_close0", 64'(upd_valid[0]), 64'd0);

    // reverse order y then x on ch1
    y_pulse = 1'b1; tick(); quiet();
    tick(); tick();
    x_pulse = 8'h02; tick(); quiet();
    chk("reverse_prob1", 64'(prob_of(1)), 64'd20);
    chk("reverse_inc1",  64'(upd_inc[1]), 64'd0);
    gamma_end = 1'b1; tick(); quiet();

    // x only on ch2 closed by gamma_end
    x_pulse = 8'h04; tick(); quiet();
    gamma_end = 1'b1; tick(); quiet();
    chk("search_prob2", 64'(prob_of(2)), 64'd60);
    chk("search_inc2",  64'(upd_inc[2]), 64'd1);
    chk("search_idle",  64'(upd_valid),  64'h04);

    // y only closed by gamma_end
    y_pulse = 1'b1; tick(); quiet();
    gamma_end = 1'b1; tick(); quiet();
    chk("backoff_prob3", 64'(prob_of(3)), 64'd5);
    chk("backoff_inc3",  64'(upd_inc[3]), 64'd0);

    // back-to-back empty windows
    gamma_end = 1'b1; tick(); tick(); quiet();
    chk("empty_close", 64'(upd_valid), 64'd0);

    // tie on ch4
    x_pulse = 8'h10; y_pulse = 1'b1; tick(); quiet();
`ifdef PULSE_TIE_MINUS_EN
    chk("tie_prob4", 64'(prob_of(4)), 64'd20);
    chk("tie_inc4",  64'(upd_inc[4]), 64'd0);
`else
    chk("tie_prob4", 64'(prob_of(4)), 64'd90);
    chk("tie_inc4",  64'(upd_inc[4]), 64'd1);
`endif
    gamma_end = 1'b1; tick(); quiet();

    // x and gamma_end in the same cycle on ch5
    x_pulse = 8'h20; gamma_end = 1'b1; tick(); quiet();
    chk("samecyc_prob5", 64'(prob_of(5)), 64'd60);
    chk("samecyc_inc5",  64'(upd_inc[5]), 64'd1);

    // ch6 disabled
    ch_en = 8'hBF;
    x_pulse = 8'h40; tick(); quiet();
    y_pulse = 1'b1; tick(); quiet();
    gamma_end = 1'b1; tick(); quiet();
    chk("disabled6", 64'(upd_valid[6]), 64'd0);
    ch_en = '1;

    // reset mid-window after ch7 x
    x_pulse = 8'h80; tick(); quiet();
    rst = 1'b1; gamma_end = 1'b1; tick(); quiet();
    chk("rst_valid", 64'(upd_valid), 64'd0);
    rst = 1'b0;
    gamma_end = 1'b1; tick(); quiet();
    chk("rst_close7", 64'(upd_valid[7]), 64'd0);

    // random windows
    for (int w = 0; w < 100; w++) begin
      int len, ypos;
      len  = $urandom_range(1, 8);
      ypos = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
      for (int i = 0; i < N_CH; i++) begin cnt[i] = 0; had[i] = 0; end
      for (int c = 0; c < len; c++) begin
        x_pulse   = N_CH'($urandom & $urandom & $urandom);
        y_pulse   = (c == ypos) || (ypos >= 0 && $urandom_range(0, 5) == 0);
        gamma_end = (c == len - 1);
        for (int i = 0; i < N_CH; i++) had[i] = had[i] | x_pulse[i] | y_pulse;
        tick();
        for (int i = 0; i < N_CH; i++) cnt[i] += int'(upd_valid[i]);
      end
      quiet();
      for (int i = 0; i < N_CH; i++) chk("window_count", 64'(cnt[i]), 64'(had[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
